core_csr_sys_sequencer: RTL and testbench

- Parametrised successor to the combinational system-instruction decoder.
- Accepts one SYSTEM-opcode (7'h73) instruction at a time, decodes it with privilege and CSR-access checks, and sequences the outcome: CSR access, trap, xRET or WFI sleep.
- Trap and xRET outcomes use a pipeline-flush handshake. Sits between decode and the CSR file / trap unit of each core.

---
 rtl/core_csr_sys_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_core_csr_sys_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_csr_sys_sequencer.sv
// SYSTEM-opcode sequencer: decodes one instruction at a time with privilege and CSR
// checks, then drives a CSR strobe, a flush-handshaked trap/xRET commit, or a WFI sleep.
module core_csr_sys_sequencer #(
   parameter int unsigned XLEN        = 32,
   parameter bit          SUPPORT_S   = 1'b1,
   parameter int unsigned SLEEP_CNT_W = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [31:0]            i_instr,
   input  logic [1:0]             i_priv,
   input  logic                   i_tsr,
   input  logic                   i_tw,
   input  logic                   i_irq_pending,
   input  logic                   i_flush_ack,
   output logic                   o_csr_wen,
   output logic                   o_csr_ren,
   output logic [11:0]            o_csr_addr,
   output logic                   o_flush,
   output logic                   o_trap,
   output logic [3:0]             o_cause,
   output logic [XLEN-1:0]        o_tval,
   output logic                   o_mret,
   output logic                   o_sret,
   output logic                   o_wfi_sleep,
   output logic [SLEEP_CNT_W-1:0] o_sleep_cycles
);
   localparam logic [6:0]  OPC_SYSTEM   = 7'h73;
   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
   localparam logic [31:0] INSTR_SRET   = 32'h1020_0073;
   localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;
   localparam logic [3:0]  CAUSE_ILL    = 4'd2;
   localparam logic [3:0]  CAUSE_BRK    = 4'd3;

   typedef enum logic [2:0] {S_IDLE, S_CSR, S_FLUSH, S_COMMIT, S_SLEEP, S_WAKE} state_e;
   typedef enum logic [1:0] {OUT_TRAP, OUT_MRET, OUT_SRET} outcome_e;

   state_e                 state_q, state_d;
   outcome_e               outc_q, outc_d;
   logic [3:0]             pcause_q, pcause_d;
   logic [XLEN-1:0]        ptval_q, ptval_d;
   logic                   ready_q, ready_d;
   logic                   csr_wen_q, csr_wen_d;
   logic                   csr_ren_q, csr_ren_d;
   logic [11:0]            csr_addr_q, csr_addr_d;
   logic                   flush_q, flush_d;
   logic                   trap_q, trap_d;
   logic                   mret_q, mret_d;
   logic                   sret_q, sret_d;
   logic [3:0]             cause_q, cause_d;
   logic [XLEN-1:0]        tval_q, tval_d;
   logic                   sleep_q, sleep_d;
   logic [SLEEP_CNT_W-1:0] cnt_q, cnt_d;

   logic [2:0] f3;
   logic [1:0] csr_lvl;
   logic       is_sys, csr_wr, csr_rd;
   logic       dec_csr, dec_sleep, dec_illegal;
   outcome_e   dec_outc;
   logic [3:0] dec_cause;

   // Instruction decode with privilege / CSR access legality
   always_comb begin
      f3          = i_instr[14:12];
      csr_lvl     = i_instr[29:28];
      is_sys      = (i_instr[6:0] == OPC_SYSTEM);
      csr_wr      = (f3[1:0] == 2'b01) || (i_instr[19:15] != 5'd0);
      csr_rd      = !((f3[1:0] == 2'b01) && (i_instr[11:7] == 5'd0));
      dec_csr     = 1'b0;
      dec_sleep   = 1'b0;
      dec_illegal = 1'b0;
      dec_outc    = OUT_TRAP;
      dec_cause   = 4'd0;
      if (f3 == 3'b000) begin
         case (i_instr)
            INSTR_ECALL: begin
               case (i_priv)
                  2'b00:   dec_cause = 4'd8;
                  2'b01:   dec_cause = 4'd9;
                  default: dec_cause = 4'd11;
               endcase
            end
            INSTR_EBREAK: dec_cause = CAUSE_BRK;
            INSTR_MRET: begin
               if (i_priv != 2'b11) dec_illegal = 1'b1;
               else                 dec_outc    = OUT_MRET;
            end
            INSTR_SRET: begin
               if (!SUPPORT_S || (i_priv == 2'b00) || ((i_priv == 2'b01) && i_tsr))
                  dec_illegal = 1'b1;
               else
                  dec_outc = OUT_SRET;
            end
            INSTR_WFI: begin
               if (i_tw && (i_priv != 2'b11)) dec_illegal = 1'b1;
               else                           dec_sleep   = 1'b1;
            end
            default: dec_illegal = 1'b1;
         endcase
      end else if (f3 == 3'b100) begin
         dec_illegal = 1'b1;
      end else if ((csr_lvl > i_priv) || (csr_wr && (i_instr[31:30] == 2'b11)) ||
                   ((csr_lvl == 2'b01) && !SUPPORT_S)) begin
         dec_illegal = 1'b1;
      end else begin
         dec_csr = 1'b1;
      end
      if (dec_illegal) begin
         dec_outc  = OUT_TRAP;
         dec_cause = CAUSE_ILL;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      outc_d     = outc_q;
      pcause_d   = pcause_q;
      ptval_d    = ptval_q;
      ready_d    = ready_q;
      csr_wen_d  = 1'b0;
      csr_ren_d  = 1'b0;
      csr_addr_d = csr_addr_q;
      flush_d    = flush_q;
      trap_d     = 1'b0;
      mret_d     = 1'b0;
      sret_d     = 1'b0;
      cause_d    = 4'd0;
      tval_d     = '0;
      sleep_d    = sleep_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid && is_sys) begin
               ready_d = 1'b0;
               if (dec_csr) begin
                  state_d    = S_CSR;
                  csr_wen_d  = csr_wr;
                  csr_ren_d  = csr_rd;
                  csr_addr_d = i_instr[31:20];
               end else if (dec_sleep) begin
                  state_d = S_SLEEP;
                  sleep_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d  = S_FLUSH;
                  flush_d  = 1'b1;
                  outc_d   = dec_outc;
                  pcause_d = dec_cause;
                  ptval_d  = dec_illegal ? XLEN'(i_instr) : '0;
               end
            end
         end
         S_CSR: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         S_FLUSH: begin
            if (i_flush_ack) begin
               state_d = S_COMMIT;
               flush_d = 1'b0;
               trap_d  = (outc_q == OUT_TRAP);
               mret_d  = (outc_q == OUT_MRET);
               sret_d  = (outc_q == OUT_SRET);
               cause_d = pcause_q;
               tval_d  = ptval_q;
            end
         end
         S_COMMIT: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         S_SLEEP: begin
            cnt_d = (cnt_q == {SLEEP_CNT_W{1'b1}}) ? cnt_q : cnt_q + SLEEP_CNT_W'(1);
            if (i_irq_pending) begin
               state_d = S_WAKE;
               sleep_d = 1'b0;
            end
         end
         S_WAKE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            flush_d = 1'b0;
            sleep_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         outc_q     <= OUT_TRAP;
         pcause_q   <= 4'd0;
         ptval_q    <= '0;
         ready_q    <= 1'b1;
         csr_wen_q  <= 1'b0;
         csr_ren_q  <= 1'b0;
         csr_addr_q <= 12'd0;
         flush_q    <= 1'b0;
         trap_q     <= 1'b0;
         mret_q     <= 1'b0;
         sret_q     <= 1'b0;
         cause_q    <= 4'd0;
         tval_q     <= '0;
         sleep_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         outc_q     <= outc_d;
         pcause_q   <= pcause_d;
         ptval_q    <= ptval_d;
         ready_q    <= ready_d;
         csr_wen_q  <= csr_wen_d;
         csr_ren_q  <= csr_ren_d;
         csr_addr_q <= csr_addr_d;
         flush_q    <= flush_d;
         trap_q     <= trap_d;
         mret_q     <= mret_d;
         sret_q     <= sret_d;
         cause_q    <= cause_d;
         tval_q     <= tval_d;
         sleep_q    <= sleep_d;
         cnt_q      <= cnt_d;
      end
   end

   assign o_ready        = ready_q;
   assign o_csr_wen      = csr_wen_q;
   assign o_csr_ren      = csr_ren_q;
   assign o_csr_addr     = csr_addr_q;
   assign o_flush        = flush_q;
   assign o_trap         = trap_q;
   assign o_cause        = cause_q;
   assign o_tval         = tval_q;
   assign o_mret         = mret_q;
   assign o_sret         = sret_q;
   assign o_wfi_sleep    = sleep_q;
   assign o_sleep_cycles = cnt_q;

endmodule

// File: tb/tb_core_csr_sys_sequencer.sv
// Bench for core_csr_sys_sequencer: directed and randomized instructions against an
// outcome-level reference model; a second instance covers SUPPORT_S=0 and a 4-bit counter.
module tb_core_csr_sys_sequencer;
   localparam int K_IGN = 0, K_CSR = 1, K_TRAP = 2, K_MRET = 3, K_SRET = 4, K_SLEEP = 5;
   localparam logic [31:0] ECALL = 32'h0000_0073, EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET = 32'h3020_0073, SRET = 32'h1020_0073, WFI = 32'h1050_0073;

   typedef struct {
      int          kind;
      logic [3:0]  cause;
      logic [31:0] tval;
      logic        wen;
      logic        ren;
      logic [11:0] addr;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, use_b = 1'b0;
   logic [31:0] i_instr = 32'd0;
   logic [1:0]  i_priv = 2'b11;
   logic i_tsr = 1'b0, i_tw = 1'b0, i_irq = 1'b0, i_ack = 1'b0;
   logic a_valid, b_valid;

   logic a_ready, a_wen, a_ren, a_flush, a_trap, a_mret, a_sret, a_sleep;
   logic [11:0] a_addr;
   logic [3:0]  a_cause;
   logic [31:0] a_tval;
   logic [15:0] a_cnt;
   logic b_ready, b_wen, b_ren, b_flush, b_trap, b_mret, b_sret, b_sleep;
   logic [11:0] b_addr;
   logic [3:0]  b_cause;
   logic [31:0] b_tval;
   logic [3:0]  b_cnt;

   logic ready, wen, ren, flush, trap, mret, sret, sleep;
   logic [11:0] addr;
   logic [3:0]  cause;
   logic [31:0] tval;
   logic [15:0] cnt;

   int errs = 0, checks = 0;
   int last_cnt[2] = '{0, 0};

   assign a_valid = i_valid & ~use_b;
   assign b_valid = i_valid & use_b;
   assign ready = use_b ? b_ready : a_ready;
   assign wen   = use_b ? b_wen   : a_wen;
   assign ren   = use_b ? b_ren   : a_ren;
   assign addr  = use_b ? b_addr  : a_addr;
   assign flush = use_b ? b_flush : a_flush;
   assign trap  = use_b ? b_trap  : a_trap;
   assign cause = use_b ? b_cause : a_cause;
   assign tval  = use_b ? b_tval  : a_tval;
   assign mret  = use_b ? b_mret  : a_mret;
   assign sret  = use_b ? b_sret  : a_sret;
   assign sleep = use_b ? b_sleep : a_sleep;
   assign cnt   = use_b ? 16'(b_cnt) : a_cnt;

   always #5 clk = ~clk;

   core_csr_sys_sequencer dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready), .i_instr(i_instr),
      .i_priv(i_priv), .i_tsr(i_tsr), .i_tw(i_tw), .i_irq_pending(i_irq), .i_flush_ack(i_ack),
      .o_csr_wen(a_wen), .o_csr_ren(a_ren), .o_csr_addr(a_addr), .o_flush(a_flush),
      .o_trap(a_trap), .o_cause(a_cause), .o_tval(a_tval), .o_mret(a_mret), .o_sret(a_sret),
      .o_wfi_sleep(a_sleep), .o_sleep_cycles(a_cnt));

   core_csr_sys_sequencer #(.XLEN(32), .SUPPORT_S(1'b0), .SLEEP_CNT_W(4)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready), .i_instr(i_instr),
      .i_priv(i_priv), .i_tsr(i_tsr), .i_tw(i_tw), .i_irq_pending(i_irq), .i_flush_ack(i_ack),
      .o_csr_wen(b_wen), .o_csr_ren(b_ren), .o_csr_addr(b_addr), .o_flush(b_flush),
      .o_trap(b_trap), .o_cause(b_cause), .o_tval(b_tval), .o_mret(b_mret), .o_sret(b_sret),
      .o_wfi_sleep(b_sleep), .o_sleep_cycles(b_cnt));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Architectural outcome of one instruction, straight from the decode rules
   function automatic exp_t model(input logic [31:0] w, input logic [1:0] p, input logic tsr,
                                  input logic tw, input bit sup_s);
      exp_t e;
      logic [2:0] f3;
      logic [1:0] lvl;
      bit ill, wr, rd, wr_always;
      e.kind = K_IGN; e.cause = 4'd0; e.tval = 32'd0; e.wen = 1'b0; e.ren = 1'b0;
      e.addr = w[31:20];
      f3 = w[14:12];
      lvl = w[29:28];
      ill = 1'b0;
      if (w[6:0] != 7'h73) return e;
      if (f3 == 3'd0) begin
         if (w == ECALL) begin e.kind = K_TRAP; e.cause = 4'(8 + int'(p)); end
         else if (w == EBREAK) begin e.kind = K_TRAP; e.cause = 4'd3; end
         else if (w == MRET) begin if (p == 2'd3) e.kind = K_MRET; else ill = 1'b1; end
         else if (w == SRET) begin
            if (sup_s && p != 2'd0 && !(p == 2'd1 && tsr)) e.kind = K_SRET; else ill = 1'b1;
         end
         else if (w == WFI) begin if (tw && p != 2'd3) ill = 1'b1; else e.kind = K_SLEEP; end
         else ill = 1'b1;
      end else if (f3 == 3'd4) begin
         ill = 1'b1;
      end else begin
         wr_always = (f3 == 3'd1) || (f3 == 3'd5);
         wr = wr_always || (w[19:15] != 5'd0);
         rd = !(wr_always && w[11:7] == 5'd0);
         if (lvl > p || (wr && w[31:30] == 2'd3) || (lvl == 2'd1 && !sup_s)) ill = 1'b1;
         else begin e.kind = K_CSR; e.wen = wr; e.ren = rd; end
      end
      if (ill) begin e.kind = K_TRAP; e.cause = 4'd2; e.tval = w; end
      return e;
   endfunction

   function automatic logic [31:0] garbage();
      return ($urandom() & 32'hFFFF_FF80) | 32'h73;
   endfunction

   // Issue one instruction from IDLE (called at a negedge) and follow it back to IDLE
   task automatic run_txn(input logic [31:0] w, input logic [1:0] p, input logic tsr,
                          input logic tw, input int dly);
      exp_t e;
      int n, cmax, bi;
      bi = use_b ? 1 : 0;
      cmax = use_b ? 15 : 65535;
      e = model(w, p, tsr, tw, !use_b);
      n = (dly < 1) ? 1 : dly;
      chk("ready_idle", 64'(ready), 64'(1));
      i_instr = w; i_priv = p; i_tsr = tsr; i_tw = tw; i_valid = 1'b1;
      i_ack = 1'($urandom_range(0, 1));
      i_irq = (e.kind == K_SLEEP && dly == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      case (e.kind)
         K_IGN: begin
            i_valid = 1'b0;
            chk("ign_ready", 64'(ready), 64'(1));
            chk("ign_strobes", 64'({wen, ren, flush, sleep, trap}), 64'(0));
         end
         K_CSR: begin
            i_valid = 1'b0;
            chk("csr_wen", 64'(wen), 64'(e.wen));
            chk("csr_ren", 64'(ren), 64'(e.ren));
            chk("csr_addr", 64'(addr), 64'(e.addr));
            chk("csr_busy", 64'({ready, flush, trap}), 64'(0));
            @(negedge clk);
            chk("csr_end", 64'({wen, ren}), 64'(0));
         end
         K_SLEEP: begin
            for (int k = 1; k <= n; k++) begin
               if (k > 1) @(negedge clk);
               chk("sleep_on", 64'({sleep, ready}), 64'(2'b10));
               chk("sleep_cnt", 64'(cnt), 64'((k - 1 < cmax) ? k - 1 : cmax));
               i_irq = (k == n);
               i_valid = 1'b1; i_instr = garbage();
            end
            @(negedge clk);
            last_cnt[bi] = (n < cmax) ? n : cmax;
            chk("wake_sleep", 64'({sleep, ready}), 64'(0));
            chk("wake_cnt", 64'(cnt), 64'(last_cnt[bi]));
            i_valid = 1'b0; i_irq = 1'($urandom_range(0, 1));
         end
         default: begin
            for (int k = 1; k <= n; k++) begin
               if (k > 1) @(negedge clk);
               chk("flush_on", 64'({flush, ready, trap, mret, sret}), 64'(5'b10000));
               i_ack = (k == n);
               i_valid = 1'b1; i_instr = garbage();
            end
            @(negedge clk);
            chk("commit_flush", 64'({flush, ready}), 64'(0));
            chk("commit_trap", 64'(trap), 64'(e.kind == K_TRAP));
            chk("commit_mret", 64'(mret), 64'(e.kind == K_MRET));
            chk("commit_sret", 64'(sret), 64'(e.kind == K_SRET));
            if (e.kind == K_TRAP) chk("commit_cause", 64'(cause), 64'(e.cause));
            chk("commit_tval", 64'(tval), 64'(e.tval));
            i_valid = 1'b0; i_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("commit_end", 64'({trap, mret, sret, flush}), 64'(0));
         end
      endcase
      if (e.kind != K_IGN) begin
         if (e.kind != K_SLEEP) i_irq = 1'($urandom_range(0, 1));
         if (e.kind == K_SLEEP) @(negedge clk);
         chk("back_ready", 64'(ready), 64'(1));
      end
      chk("cnt_hold", 64'(cnt), 64'(last_cnt[bi]));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int r;
      r = $urandom_range(0, 9);
      w = $urandom();
      if (r == 0) begin
         w[6:0] = 7'h13;
      end else if (r <= 4) begin
         case ($urandom_range(0, 6))
            0: w = ECALL;
            1: w = EBREAK;
            2: w = MRET;
            3: w = SRET;
            4: w = WFI;
            5: w = 32'h0020_0073;
            default: begin w[14:12] = 3'd0; w[6:0] = 7'h73; end
         endcase
      end else begin
         w[6:0] = 7'h73;
         w[14:12] = 3'($urandom_range(1, 7));
         if ($urandom_range(0, 2) == 0) w[19:15] = 5'd0;
         if ($urandom_range(0, 2) == 0) w[11:7] = 5'd0;
      end
      return w;
   endfunction

   function automatic logic [1:0] rand_priv();
      case ($urandom_range(0, 2))
         0: return 2'b00;
         1: return 2'b01;
         default: return 2'b11;
      endcase
   endfunction

   // Reset pulled mid-FLUSH (mode 0) or mid-SLEEP (mode 1)
   task automatic reset_mid(input int mode);
      i_instr = (mode == 0) ? MRET : WFI; i_priv = 2'b11; i_tw = 1'b0;
      i_valid = 1'b1; i_ack = 1'b0; i_irq = 1'b0;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", 64'(ready), 64'(1));
      chk("rst_flush", 64'(flush), 64'(0));
      chk("rst_sleep", 64'(sleep), 64'(0));
      chk("rst_cnt", 64'(cnt), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      i_ack = 1'b1; i_irq = 1'b1;
      last_cnt[0] = 0; last_cnt[1] = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_quiet", 64'({trap, mret, sret, flush, sleep}), 64'(0));
         chk("post_rst_ready", 64'(ready), 64'(1));
      end
      i_ack = 1'b0; i_irq = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         use_b = 1'(s);
         #1;
         chk("reset_ready", 64'(ready), 64'(1));
         chk("reset_outs", 64'({wen, ren, flush, trap, mret, sret, sleep}), 64'(0));
         chk("reset_addr", 64'(addr), 64'(0));
         chk("reset_cause", 64'(cause), 64'(0));
         chk("reset_tval", 64'(tval), 64'(0));
         chk("reset_cnt", 64'(cnt), 64'(0));
      end
      use_b = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_txn(MRET, 2'b11, 1'b0, 1'b0, 3);
      run_txn(32'h3000_22F3, 2'b11, 1'b0, 1'b0, 0);
      run_txn(32'hC000_9073, 2'b11, 1'b0, 1'b0, 1);
      run_txn(ECALL, 2'b00, 1'b0, 1'b0, 2);
      run_txn(ECALL, 2'b01, 1'b0, 1'b0, 1);
      run_txn(ECALL, 2'b11, 1'b0, 1'b0, 4);
      run_txn(SRET, 2'b01, 1'b1, 1'b0, 2);
      run_txn(SRET, 2'b01, 1'b0, 1'b0, 1);
      run_txn(EBREAK, 2'b00, 1'b0, 1'b0, 1);
      run_txn(WFI, 2'b11, 1'b0, 1'b0, 10);
      run_txn(WFI, 2'b00, 1'b0, 1'b1, 2);
      run_txn(32'h0020_0073, 2'b11, 1'b0, 1'b0, 1);
      run_txn(32'h0000_0013, 2'b11, 1'b0, 1'b0, 0);
      run_txn(WFI, 2'b11, 1'b0, 1'b0, 0);

      use_b = 1'b1;
      run_txn(WFI, 2'b11, 1'b0, 1'b0, 40);
      run_txn(SRET, 2'b11, 1'b0, 1'b0, 1);
      run_txn(32'h1000_20F3, 2'b11, 1'b0, 1'b0, 1);
      use_b = 1'b0;

      reset_mid(0);
      reset_mid(1);

      for (int i = 0; i < 200; i++) begin
         use_b = ($urandom_range(0, 4) == 0);
         run_txn(rand_instr(), rand_priv(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), $urandom_range(0, 6));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
